// File: rtl/wb_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// wb_scoreboard_pkg
// Shared types and constants for the write-back scoreboard.
//   AW          register address width
//   reg_addr_t  register address type
//   sb_entry_t  one scoreboard slot: valid flag + pending destination address
//   REG_ZERO    the hard-wired zero register; it never produces a hazard
// -----------------------------------------------------------------------------
package wb_scoreboard_pkg;

   localparam int AW = 5;

   typedef logic [AW-1:0] reg_addr_t;

   typedef struct packed {
      logic      valid;
      reg_addr_t rd;
   } sb_entry_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage : wb_scoreboard_pkg

// File: rtl/wb_scoreboard_if.sv
// -----------------------------------------------------------------------------
// wb_scoreboard_if
// Bundle of every non-clock/reset signal of the scoreboard.
//   master modport : pipeline side (issue, writeback and decode stages)
//   slave modport  : the scoreboard itself
// Signals:
//   flush_i                       pipeline flush, discards all pending entries
//   alloc_valid_i/alloc_rd_i      record a new pending write
//   alloc_ready_o                 a free slot exists
//   cmpl_valid_i                  oldest pending write completed
//   cmpl_rd_o                     destination of oldest entry (0 when empty)
//   cmpl_err_o                    one-cycle pulse: completion seen while empty
//   rs1_i/rs2_i/rd_i              decode-stage addresses to check
//   rs1_hit_o/rs2_hit_o/rd_hit_o  per-address collision flags
//   stall_o                       OR of the hit flags
//   count_o/empty_o/full_o        occupancy
// -----------------------------------------------------------------------------
interface wb_scoreboard_if
   import wb_scoreboard_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) ();

   logic          flush_i;
   logic          alloc_valid_i;
   reg_addr_t     alloc_rd_i;
   logic          alloc_ready_o;
   logic          cmpl_valid_i;
   reg_addr_t     cmpl_rd_o;
   logic          cmpl_err_o;
   reg_addr_t     rs1_i;
   reg_addr_t     rs2_i;
   reg_addr_t     rd_i;
   logic          rs1_hit_o;
   logic          rs2_hit_o;
   logic          rd_hit_o;
   logic          stall_o;
   logic [CW-1:0] count_o;
   logic          empty_o;
   logic          full_o;

   modport master (
      output flush_i, alloc_valid_i, alloc_rd_i, cmpl_valid_i,
             rs1_i, rs2_i, rd_i,
      input  alloc_ready_o, cmpl_rd_o, cmpl_err_o,
             rs1_hit_o, rs2_hit_o, rd_hit_o, stall_o,
             count_o, empty_o, full_o
   );

   modport slave (
      input  flush_i, alloc_valid_i, alloc_rd_i, cmpl_valid_i,
             rs1_i, rs2_i, rd_i,
      output alloc_ready_o, cmpl_rd_o, cmpl_err_o,
             rs1_hit_o, rs2_hit_o, rd_hit_o, stall_o,
             count_o, empty_o, full_o
   );

endinterface : wb_scoreboard_if

// File: rtl/wb_scoreboard_addr_match.sv
// -----------------------------------------------------------------------------
// wb_scoreboard_addr_match
// Address-match cell: compares one scoreboard entry against one query address.
//   valid  entry holds a pending write
//   rd     entry destination address
//   query  decode-stage address being checked
//   hit    entry is pending on that address; address 0 never hits
// -----------------------------------------------------------------------------
module wb_scoreboard_addr_match
   import wb_scoreboard_pkg::*;
(
   input  logic      valid,
   input  reg_addr_t rd,
   input  reg_addr_t query,
   output logic      hit
);

   assign hit = valid && (rd == query) && (query != REG_ZERO);

endmodule : wb_scoreboard_addr_match

// File: rtl/wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
// In-order tracker of register-file writes still in flight. The issue stage
// allocates an entry per long-latency instruction, writeback retires the oldest
// one, and every cycle the decode-stage addresses are checked against all
// pending destinations to raise a hazard stall.
// Ports:
//   clk_i  clock, all state changes on the rising edge
//   rst_i  synchronous active-high reset (overrides flush, alloc, completion)
//   sb     wb_scoreboard_if.slave, see the interface header for signals
// DEPTH must be a power of two >= 2 so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module wb_scoreboard
   import wb_scoreboard_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   wb_scoreboard_if.slave sb
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   sb_entry_t     entry_reg [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          cmpl_err_reg;

   logic          full;
   logic          empty;
   logic          alloc_fire;
   logic          cmpl_fire;

   // Occupancy comes from the count register; pointer equality is ambiguous
   // between full and empty.
   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);

   // No full-bypass: a simultaneous completion does not free a slot this cycle.
   assign alloc_fire = sb.alloc_valid_i && !full;
   assign cmpl_fire  = sb.cmpl_valid_i && !empty;

   // alloc_fire and cmpl_fire can only target the same slot when the pointers
   // are equal, which means full or empty, and each is blocked in one of those
   // cases, so the two writes below never collide.
   always_ff @(posedge clk_i) begin
      if (rst_i || sb.flush_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_reg[i] <= '{valid: 1'b0, rd: REG_ZERO};
         end
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         cmpl_err_reg <= 1'b0;
      end else begin
         cmpl_err_reg <= sb.cmpl_valid_i && empty;

         if (alloc_fire) begin
            entry_reg[wr_ptr_reg] <= '{valid: 1'b1, rd: sb.alloc_rd_i};
            wr_ptr_reg            <= wr_ptr_reg + PW'(1);
         end

         if (cmpl_fire) begin
            entry_reg[rd_ptr_reg].valid <= 1'b0;
            rd_ptr_reg                  <= rd_ptr_reg + PW'(1);
         end

         if (alloc_fire && !cmpl_fire) begin
            count_reg <= count_reg + CW'(1);
         end else if (!alloc_fire && cmpl_fire) begin
            count_reg <= count_reg - CW'(1);
         end
      end
   end

   // Hit detection: one match cell per entry per query port, OR-reduced.
   // Works on registered state only, so a new entry is visible the cycle
   // after allocation and a retiring entry still hits in its retire cycle.
   logic [DEPTH-1:0] rs1_match;
   logic [DEPTH-1:0] rs2_match;
   logic [DEPTH-1:0] rd_match;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
         wb_scoreboard_addr_match u_rs1 (
            .valid (entry_reg[gi].valid),
            .rd    (entry_reg[gi].rd),
            .query (sb.rs1_i),
            .hit   (rs1_match[gi])
         );
         wb_scoreboard_addr_match u_rs2 (
            .valid (entry_reg[gi].valid),
            .rd    (entry_reg[gi].rd),
            .query (sb.rs2_i),
            .hit   (rs2_match[gi])
         );
         wb_scoreboard_addr_match u_rd (
            .valid (entry_reg[gi].valid),
            .rd    (entry_reg[gi].rd),
            .query (sb.rd_i),
            .hit   (rd_match[gi])
         );
      end
   endgenerate

   assign sb.rs1_hit_o     = |rs1_match;
   assign sb.rs2_hit_o     = |rs2_match;
   assign sb.rd_hit_o      = |rd_match;
   assign sb.stall_o       = sb.rs1_hit_o || sb.rs2_hit_o || sb.rd_hit_o;

   // The slot under rd_ptr may hold a stale address once retired; mask it.
   assign sb.cmpl_rd_o     = empty ? REG_ZERO : entry_reg[rd_ptr_reg].rd;
   assign sb.cmpl_err_o    = cmpl_err_reg;

   assign sb.alloc_ready_o = !full;
   assign sb.count_o       = count_reg;
   assign sb.empty_o       = empty;
   assign sb.full_o        = full;

endmodule : wb_scoreboard

// File: tb/tb_wb_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_wb_scoreboard
// Self-checking bench for wb_scoreboard. A queue of pending destination
// addresses models the scoreboard; expected outputs are computed from it.
// -----------------------------------------------------------------------------
module tb_wb_scoreboard;
   import wb_scoreboard_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int VW    = CW + 13;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   wb_scoreboard_if #(.DEPTH(DEPTH)) sb ();

   wb_scoreboard #(.DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .sb    (sb)
   );

   // Reference model: oldest pending write at the front of the queue.
   reg_addr_t mq[$];
   logic      m_err = 1'b0;

   logic [VW-1:0] obs;
   assign obs = {sb.count_o, sb.empty_o, sb.full_o, sb.alloc_ready_o,
                 sb.cmpl_rd_o, sb.cmpl_err_o,
                 sb.rs1_hit_o, sb.rs2_hit_o, sb.rd_hit_o, sb.stall_o};

   function automatic logic [VW-1:0] expect_vec();
      int            n;
      logic          h1, h2, h3;
      logic [CW-1:0] cnt;
      reg_addr_t     oldest;
      n  = mq.size();
      h1 = 1'b0;
      h2 = 1'b0;
      h3 = 1'b0;
      foreach (mq[i]) begin
         if (mq[i] == sb.rs1_i && sb.rs1_i != 0) h1 = 1'b1;
         if (mq[i] == sb.rs2_i && sb.rs2_i != 0) h2 = 1'b1;
         if (mq[i] == sb.rd_i  && sb.rd_i  != 0) h3 = 1'b1;
      end
      cnt    = CW'(n);
      oldest = (n > 0) ? mq[0] : '0;
      return {cnt, (n == 0), (n == DEPTH), (n != DEPTH), oldest, m_err,
              h1, h2, h3, (h1 | h2 | h3)};
   endfunction

   task automatic drive(input logic f, input logic a, input int ard,
                        input logic c, input int r1, input int r2, input int rdd);
      sb.flush_i       = f;
      sb.alloc_valid_i = a;
      sb.alloc_rd_i    = reg_addr_t'(ard);
      sb.cmpl_valid_i  = c;
      sb.rs1_i         = reg_addr_t'(r1);
      sb.rs2_i         = reg_addr_t'(r2);
      sb.rd_i          = reg_addr_t'(rdd);
      #1;
   endtask

   // One clock edge; the model advances with the inputs held across the edge.
   task automatic tick();
      logic pre_empty, pre_full;
      @(posedge clk);
      if (rst || sb.flush_i) begin
         mq.delete();
         m_err = 1'b0;
      end else begin
         pre_empty = (mq.size() == 0);
         pre_full  = (mq.size() == DEPTH);
         m_err     = sb.cmpl_valid_i && pre_empty;
         if (sb.cmpl_valid_i && !pre_empty) void'(mq.pop_front());
         if (sb.alloc_valid_i && !pre_full) mq.push_back(sb.alloc_rd_i);
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b1, 9, 1'b1, 0, 0, 0);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 0, 1'b0, 5, 6, 7);
      tests_run++;
      if (obs !== expect_vec()) begin
         tests_failed++;
         $display("FAIL reset_vec: got %h want %h", obs, expect_vec());
      end
      tests_run++;
      if ({sb.count_o, sb.empty_o, sb.full_o, sb.alloc_ready_o, sb.cmpl_rd_o, sb.stall_o}
          !== {CW'(0), 1'b1, 1'b0, 1'b1, 5'd0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_outputs: got cnt=%0d empty=%b full=%b ready=%b cmpl_rd=%0d stall=%b want 0 1 0 1 0 0",
                  sb.count_o, sb.empty_o, sb.full_o, sb.alloc_ready_o, sb.cmpl_rd_o, sb.stall_o);
      end
   endtask

   task automatic test_basic_hit();
      drive(1'b0, 1'b1, 5, 1'b0, 0, 0, 0);
      tick();
      drive(1'b0, 1'b0, 0, 1'b0, 5, 6, 0);
      tests_run++;
      if (sb.count_o !== CW'(1) || sb.rs1_hit_o !== 1'b1 || sb.stall_o !== 1'b1 ||
          sb.rs2_hit_o !== 1'b0 || sb.cmpl_rd_o !== 5'd5) begin
         tests_failed++;
         $display("FAIL basic_hit: got cnt=%0d rs1=%b stall=%b rs2=%b cmpl_rd=%0d want 1 1 1 0 5",
                  sb.count_o, sb.rs1_hit_o, sb.stall_o, sb.rs2_hit_o, sb.cmpl_rd_o);
      end
      drive(1'b0, 1'b0, 0, 1'b1, 5, 0, 0);
      tests_run++;
      if (sb.rs1_hit_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL hit_in_retire_cycle: got %b want 1", sb.rs1_hit_o);
      end
      tick();
      drive(1'b0, 1'b0, 0, 1'b0, 5, 0, 0);
      tests_run++;
      if (obs !== expect_vec() || sb.rs1_hit_o !== 1'b0 || sb.empty_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL hit_after_retire: got %h want %h", obs, expect_vec());
      end
   endtask

   task automatic test_zero_rd();
      drive(1'b0, 1'b1, 0, 1'b0, 0, 0, 0);
      tick();
      drive(1'b0, 1'b1, 3, 1'b0, 0, 0, 0);
      tests_run++;
      if (sb.rs1_hit_o !== 1'b0 || sb.count_o !== CW'(1)) begin
         tests_failed++;
         $display("FAIL zero_rd: got rs1=%b cnt=%0d want 0 1", sb.rs1_hit_o, sb.count_o);
      end
      tick();
      drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 3);
      tests_run++;
      if (sb.rd_hit_o !== 1'b1 || sb.count_o !== CW'(2) || sb.cmpl_rd_o !== 5'd0) begin
         tests_failed++;
         $display("FAIL waw_hit: got rd_hit=%b cnt=%0d cmpl_rd=%0d want 1 2 0",
                  sb.rd_hit_o, sb.count_o, sb.cmpl_rd_o);
      end
      drive(1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
      tick();
      drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 3);
      tests_run++;
      if (obs !== expect_vec() || sb.count_o !== CW'(0)) begin
         tests_failed++;
         $display("FAIL flush_clear: got %h want %h", obs, expect_vec());
      end
   endtask

   task automatic test_full_no_bypass();
      for (int v = 7; v <= 10; v++) begin
         drive(1'b0, 1'b1, v, 1'b0, 0, 0, 0);
         tick();
      end
      drive(1'b0, 1'b0, 0, 1'b0, 7, 0, 0);
      tests_run++;
      if (sb.full_o !== 1'b1 || sb.alloc_ready_o !== 1'b0 || sb.count_o !== CW'(4)) begin
         tests_failed++;
         $display("FAIL full: got full=%b ready=%b cnt=%0d want 1 0 4",
                  sb.full_o, sb.alloc_ready_o, sb.count_o);
      end
      drive(1'b0, 1'b1, 11, 1'b1, 7, 0, 0);
      tests_run++;
      if (sb.alloc_ready_o !== 1'b0 || sb.rs1_hit_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL no_bypass_ready: got ready=%b rs1=%b want 0 1",
                  sb.alloc_ready_o, sb.rs1_hit_o);
      end
      tick();
      drive(1'b0, 1'b0, 0, 1'b0, 7, 11, 0);
      tests_run++;
      if (sb.count_o !== CW'(3) || sb.cmpl_rd_o !== 5'd8 ||
          sb.rs1_hit_o !== 1'b0 || sb.rs2_hit_o !== 1'b0 || obs !== expect_vec()) begin
         tests_failed++;
         $display("FAIL no_bypass_after: got cnt=%0d cmpl_rd=%0d rs1=%b rs2=%b want 3 8 0 0",
                  sb.count_o, sb.cmpl_rd_o, sb.rs1_hit_o, sb.rs2_hit_o);
      end
      drive(1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
      tick();
   endtask

   task automatic test_wraparound();
      int prev;
      drive(1'b0, 1'b1, 20, 1'b0, 0, 0, 0);
      tick();
      prev = 20;
      for (int i = 1; i <= 6; i++) begin
         drive(1'b0, 1'b1, i, 1'b1, prev, i, 0);
         tests_run++;
         if (obs !== expect_vec() || sb.rs1_hit_o !== 1'b1 || sb.rs2_hit_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_pre[%0d]: got %h want %h", i, obs, expect_vec());
         end
         tick();
         drive(1'b0, 1'b0, 0, 1'b0, prev, i, 0);
         tests_run++;
         if (sb.count_o !== CW'(1) || sb.cmpl_rd_o !== reg_addr_t'(i) ||
             sb.rs1_hit_o !== 1'b0 || sb.rs2_hit_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_post[%0d]: got cnt=%0d cmpl_rd=%0d rs1=%b rs2=%b want 1 %0d 0 1",
                     i, sb.count_o, sb.cmpl_rd_o, sb.rs1_hit_o, sb.rs2_hit_o, i);
         end
         prev = i;
      end
      drive(1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
      tick();
   endtask

   task automatic test_cmpl_err();
      drive(1'b0, 1'b0, 0, 1'b1, 0, 0, 0);
      tick();
      drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
      tests_run++;
      if (sb.cmpl_err_o !== 1'b1 || sb.count_o !== CW'(0)) begin
         tests_failed++;
         $display("FAIL cmpl_err_pulse: got err=%b cnt=%0d want 1 0", sb.cmpl_err_o, sb.count_o);
      end
      tick();
      tests_run++;
      if (sb.cmpl_err_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL cmpl_err_one_cycle: got %b want 0", sb.cmpl_err_o);
      end
      drive(1'b1, 1'b0, 0, 1'b1, 0, 0, 0);
      tick();
      drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
      tests_run++;
      if (sb.cmpl_err_o !== 1'b0 || obs !== expect_vec()) begin
         tests_failed++;
         $display("FAIL cmpl_err_flush: got err=%b want 0", sb.cmpl_err_o);
      end
   endtask

   task automatic test_dup_flush_reset();
      drive(1'b0, 1'b1, 2, 1'b0, 0, 0, 0);
      tick();
      tick();
      drive(1'b0, 1'b0, 0, 1'b1, 0, 0, 0);
      tick();
      drive(1'b0, 1'b0, 0, 1'b0, 2, 0, 0);
      tests_run++;
      if (sb.rs1_hit_o !== 1'b1 || sb.count_o !== CW'(1)) begin
         tests_failed++;
         $display("FAIL dup_persist: got rs1=%b cnt=%0d want 1 1", sb.rs1_hit_o, sb.count_o);
      end
      drive(1'b0, 1'b0, 0, 1'b1, 2, 0, 0);
      tick();
      drive(1'b0, 1'b0, 0, 1'b0, 2, 0, 0);
      tests_run++;
      if (sb.rs1_hit_o !== 1'b0 || sb.empty_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL dup_clear: got rs1=%b empty=%b want 0 1", sb.rs1_hit_o, sb.empty_o);
      end
      for (int v = 1; v <= 3; v++) begin
         drive(1'b0, 1'b1, v, 1'b0, 0, 0, 0);
         tick();
      end
      drive(1'b1, 1'b1, 4, 1'b0, 4, 1, 2);
      tick();
      drive(1'b0, 1'b0, 0, 1'b0, 4, 1, 2);
      tests_run++;
      if (sb.count_o !== CW'(0) || sb.empty_o !== 1'b1 || sb.stall_o !== 1'b0 ||
          obs !== expect_vec()) begin
         tests_failed++;
         $display("FAIL flush_with_alloc: got cnt=%0d empty=%b stall=%b want 0 1 0",
                  sb.count_o, sb.empty_o, sb.stall_o);
      end
      drive(1'b0, 1'b1, 5, 1'b0, 0, 0, 0);
      tick();
      drive(1'b0, 1'b1, 6, 1'b0, 0, 0, 0);
      tick();
      rst = 1'b1;
      drive(1'b0, 1'b1, 7, 1'b1, 5, 6, 7);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 0, 1'b0, 5, 6, 7);
      tests_run++;
      if ({sb.count_o, sb.empty_o, sb.full_o, sb.alloc_ready_o, sb.cmpl_rd_o,
           sb.cmpl_err_o, sb.stall_o} !== {CW'(0), 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL mid_reset: got %h want %h", obs, expect_vec());
      end
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         drive(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)));
         tests_run++;
         if (obs !== expect_vec()) begin
            tests_failed++;
            errs++;
            if (errs <= 10)
               $display("FAIL random[%0d]: got %h want %h", n, obs, expect_vec());
         end
         tick();
      end
      rst = 1'b0;
      drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
   endtask

   initial begin
      drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
      test_reset();
      test_basic_hit();
      test_zero_rd();
      test_full_no_bypass();
      test_wraparound();
      test_cmpl_err();
      test_dup_flush_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_wb_scoreboard
